serial_adder_nbit: RTL

//   Parametrised digit-serial adder/subtractor, successor to the single-bit full adder.

---
 rtl/serial_adder_nbit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_adder_nbit.sv
// Digit-serial adder/subtractor: a DIGIT-bit ripple slice plus carry flip-flop iterated
// WIDTH/DIGIT times, with valid/ready handshakes on the operand and result sides.
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int BEATS = WIDTH / DIGIT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_nbit: WIDTH must be >= 2 and an exact multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [DIGIT:0]   w_digit;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_res_next;

    assign w_digit = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

    // Carry into the slice MSB recovered from its sum bit, since s = a ^ b ^ c.
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_digit[DIGIT-1];

    // Result bits enter at the MSB end so after the last beat the register is LSB-aligned.
    if (DIGIT == WIDTH) begin : g_single_beat
        assign w_res_next = w_digit[DIGIT-1:0];
    end else begin : g_multi_beat
        assign w_res_next = {w_digit[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
    end

    // NOTE: every register in this block uses <= so all of them sample the pre-edge values;
    // a blocking update of r_a here would feed the shifted operand into w_digit too early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= sub ? ~op_b : op_b;
                        r_carry    <= sub ? ~cin : cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_digit[DIGIT];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BEAT) begin
                        r_sum       <= w_res_next;
                        r_cout      <= w_digit[DIGIT];
                        r_ovf       <= w_msb_cin ^ w_digit[DIGIT];
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
